// File: rtl/acess_pkg.sv
// Shared definitions for the keypad access controller.
//
// Contents:
//   estado_e  - controller states (ENTRADA, VERIFICA, ABERTO, BLOQUEADO)
//   ESTADO_W  - width of the state encoding, used for the debug port
//   cnt_w()   - width of a counter that must hold 0..n-1 (never below 1),
//               used for the digit index and the lockout timer
package acess_pkg;

  typedef enum logic [1:0] {
    ENTRADA   = 2'd0,
    VERIFICA  = 2'd1,
    ABERTO    = 2'd2,
    BLOQUEADO = 2'd3
  } estado_e;

  localparam int ESTADO_W = 2;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rom_senha.sv
// Stored-password ROM: synchronous single-port read, one cycle latency.
//
// Parameters:
//   DIGIT_W    - bits per stored digit
//   PASS_LEN   - number of stored digits
//   INIT_FILE  - name of the password image; an empty name means an
//                unprogrammed (all-zero) ROM
//   INIT_WORDS - password image baked in at elaboration, word 0 in the
//                least significant DIGIT_W bits (address 0 = first digit)
//
// Ports:
//   clk      - clock, read on rising edge
//   addr     - word address
//   data_out - registered word at addr, valid one cycle after addr
module rom_senha
  import acess_pkg::*;
#(
  parameter int                            DIGIT_W    = 4,
  parameter int                            PASS_LEN   = 4,
  parameter string                         INIT_FILE  = "senha.mem",
  parameter logic [DIGIT_W*PASS_LEN-1:0]   INIT_WORDS = '0
) (
  input  logic                        clk,
  input  logic [cnt_w(PASS_LEN)-1:0]  addr,
  output logic [DIGIT_W-1:0]          data_out
);

  localparam logic [DIGIT_W*PASS_LEN-1:0] ROM_IMG =
    (INIT_FILE == "") ? '0 : INIT_WORDS;

  logic [DIGIT_W-1:0] words [PASS_LEN];

  for (genvar g = 0; g < PASS_LEN; g++) begin : g_word
    assign words[g] = ROM_IMG[g*DIGIT_W +: DIGIT_W];
  end

  // Pure read path: no reset needed, the controller ignores data_out until
  // its rom_ok flag says the addressed word has arrived.
  always_ff @(posedge clk) begin
    data_out <= words[addr];
  end

endmodule

// File: rtl/ctrl_acesso_param.sv
// Parametrised keypad access controller.
//
// Collects PASS_LEN digits, compares each one against the stored password
// as it arrives, and only after the full entry gives a verdict: open the
// door, or count a failed attempt. MAX_TENT consecutive failures lock the
// keypad for LOCK_CYC cycles. The door stays unlocked until fechou.
//
// Handshake: a digit transfers on a rising edge where digito_valido and
// pronto are both high. digito_valido while pronto is low is dropped, not
// held; the keypad side must re-present it.
//
// Ports:
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   digito_valido  - digit strobe
//   digito         - digit value, sampled with digito_valido
//   cancela        - abort the current entry (no attempt consumed)
//   fechou         - door-closed sensor
//   pronto         - ready for a digit
//   aberto         - door unlocked
//   erro           - one-cycle pulse on a failed attempt
//   bloqueado      - lockout active
//   tentativas     - consecutive failed attempts so far
//   estado_dbg     - current FSM state (debug)
module ctrl_acesso_param
  import acess_pkg::*;
#(
  parameter int                          DIGIT_W    = 4,
  parameter int                          PASS_LEN   = 4,
  parameter int                          MAX_TENT   = 3,
  parameter int                          LOCK_CYC   = 1024,
  parameter string                       INIT_FILE  = "senha.mem",
  parameter logic [DIGIT_W*PASS_LEN-1:0] INIT_WORDS = 16'h4321
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              digito_valido,
  input  logic [DIGIT_W-1:0]                digito,
  input  logic                              cancela,
  input  logic                              fechou,
  output logic                              pronto,
  output logic                              aberto,
  output logic                              erro,
  output logic                              bloqueado,
  output logic [$clog2(MAX_TENT+1)-1:0]     tentativas,
  output logic [ESTADO_W-1:0]               estado_dbg
);

  localparam int IDX_W  = cnt_w(PASS_LEN);
  localparam int TENT_W = $clog2(MAX_TENT + 1);
  localparam int TMR_W  = cnt_w(LOCK_CYC);

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PASS_LEN - 1);
  localparam logic [TENT_W-1:0] TENT_MAX = TENT_W'(MAX_TENT);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(LOCK_CYC - 1);

  estado_e            state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               falha_q, falha_d;
  logic [TENT_W-1:0]  tent_q, tent_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               rom_ok_q, rom_ok_d;
  logic               aberto_q, erro_q, bloq_q;
  logic               erro_d;
  logic               idx_load;
  logic [TENT_W-1:0]  tent_inc;
  logic [DIGIT_W-1:0] rom_data;

  rom_senha #(
    .DIGIT_W    (DIGIT_W),
    .PASS_LEN   (PASS_LEN),
    .INIT_FILE  (INIT_FILE),
    .INIT_WORDS (INIT_WORDS)
  ) u_rom (
    .clk      (clk),
    .addr     (idx_q),
    .data_out (rom_data)
  );

  // rom_ok tracks whether rom_data belongs to the current idx. Every idx
  // load (including reloading 0) invalidates it for one cycle, which is
  // what spaces accepted digits two cycles apart and delays pronto after
  // reset, cancel and every return to ENTRADA.
  assign pronto = (state_q == ENTRADA) && rom_ok_q;

  // Saturating increment; the lockout normally fires before saturation.
  assign tent_inc = (tent_q == TENT_MAX) ? tent_q : tent_q + TENT_W'(1);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    falha_d  = falha_q;
    tent_d   = tent_q;
    timer_d  = timer_q;
    erro_d   = 1'b0;
    idx_load = 1'b0;

    case (state_q)
      ENTRADA: begin
        if (cancela) begin
          // Cancel beats a simultaneous digit.
          idx_d    = '0;
          falha_d  = 1'b0;
          idx_load = 1'b1;
        end else if (digito_valido && pronto) begin
          // Mismatches are only accumulated; the verdict waits for the last
          // digit so the response time says nothing about where it failed.
          falha_d = falha_q | (digito != rom_data);
          if (idx_q == IDX_LAST) begin
            state_d = VERIFICA;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            idx_load = 1'b1;
          end
        end
      end

      VERIFICA: begin
        idx_d    = '0;
        falha_d  = 1'b0;
        idx_load = 1'b1;
        if (!falha_q) begin
          state_d = ABERTO;
          tent_d  = '0;
        end else begin
          erro_d = 1'b1;
          tent_d = tent_inc;
          if (tent_inc == TENT_MAX) begin
            state_d = BLOQUEADO;
            timer_d = TMR_LOAD;
          end else begin
            state_d = ENTRADA;
          end
        end
      end

      ABERTO: begin
        if (fechou) begin
          state_d  = ENTRADA;
          idx_d    = '0;
          idx_load = 1'b1;
        end
      end

      BLOQUEADO: begin
        // Loaded with LOCK_CYC-1 and left on reaching zero: LOCK_CYC
        // cycles in this state in total.
        if (timer_q == '0) begin
          state_d  = ENTRADA;
          tent_d   = '0;
          idx_d    = '0;
          idx_load = 1'b1;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      default: begin
        state_d  = ENTRADA;
        idx_d    = '0;
        falha_d  = 1'b0;
        idx_load = 1'b1;
      end
    endcase

    rom_ok_d = !idx_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ENTRADA;
      idx_q    <= '0;
      falha_q  <= 1'b0;
      tent_q   <= '0;
      timer_q  <= '0;
      rom_ok_q <= 1'b0;
      aberto_q <= 1'b0;
      erro_q   <= 1'b0;
      bloq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      falha_q  <= falha_d;
      tent_q   <= tent_d;
      timer_q  <= timer_d;
      rom_ok_q <= rom_ok_d;
      aberto_q <= (state_d == ABERTO);
      erro_q   <= erro_d;
      bloq_q   <= (state_d == BLOQUEADO);
    end
  end

  assign aberto     = aberto_q;
  assign erro       = erro_q;
  assign bloqueado  = bloq_q;
  assign tentativas = tent_q;
  assign estado_dbg = state_q;

endmodule
